// File: rtl/add_issue_pkg.sv
// rtl/add_issue_pkg.sv - shared widths, result record and FSM encodings for the adder issue controller
package add_issue_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_LAT   = 4;
    localparam int ADD_DEPTH = 4;
    localparam int ADD_TAGW  = 4;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] s;
        logic                 cout;
        logic [ADD_TAGW-1:0]  tag;
    } result_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_RUN        = 2'd1;
    localparam state_t ST_CHAIN_WAIT = 2'd2;

endpackage

// File: rtl/add_issue_ctrl_result_fifo.sv
// rtl/add_issue_ctrl_result_fifo.sv - synchronous result FIFO, head entry always visible on data_out
module result_fifo
    import add_issue_pkg::*;
#(
    parameter int DEPTH = ADD_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  result_t       data_in,
    output result_t       data_out,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    result_t       mem_q [DEPTH];
    result_t       mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Pop only real entries; a push into a full FIFO is allowed when a pop frees the slot in the same cycle
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = data_in;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/add_issue_ctrl.sv
// rtl/add_issue_ctrl.sv - credit-based issue/retire controller wrapped around a fixed-latency pipelined adder
module add_issue_ctrl
    import add_issue_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int LAT   = ADD_LAT,
    parameter int DEPTH = ADD_DEPTH,
    parameter int TAGW  = ADD_TAGW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    input  logic [TAGW-1:0]  in_tag,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic [TAGW-1:0]  out_tag
);

    localparam int IFW = $clog2(LAT + 2);
    localparam int CW  = $clog2(DEPTH + 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       add_a_q, add_a_d;
    logic [WIDTH-1:0]       add_b_q, add_b_d;
    logic                   add_cin_q, add_cin_d;
    logic [LAT:0]           pipe_v_q, pipe_v_d;
    logic [LAT:0][TAGW-1:0] pipe_tag_q, pipe_tag_d;
    logic                   last_cout_q, last_cout_d;

    logic [IFW-1:0]         inflight;
    logic                   credit_ok;
    logic                   chain_block;
    logic                   ready_w;
    logic                   accept;
    logic                   fifo_push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    result_t                fifo_in;
    result_t                fifo_out;

    // Credit: every in-flight op owns a FIFO slot, since the adder cannot be stalled
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + IFW'(pipe_v_q[i]);
        end
        credit_ok   = (int'(fifo_count) + int'(inflight)) < DEPTH;
        chain_block = in_valid && in_chain && (inflight != '0);
    end

    // Issue FSM: a chained request waits until the previous result has retired and updated last_cout
    always_comb begin
        state_d = state_q;
        ready_w = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                ready_w = credit_ok && !chain_block;
                if (chain_block) begin
                    state_d = ST_CHAIN_WAIT;
                end else if (in_valid && ready_w) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN && pipe_v_q[LAT-1:0] == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHAIN_WAIT: begin
                ready_w = (inflight == '0) && credit_ok;
                if (in_valid && ready_w) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready = rst_n && ready_w;
    assign accept   = in_valid && in_ready;

    // Operand registers, tag/valid pipe aligned with adder latency, and retire capture
    always_comb begin
        add_a_d     = accept ? in_a : add_a_q;
        add_b_d     = accept ? in_b : add_b_q;
        add_cin_d   = accept ? (in_chain ? last_cout_q : in_cin) : add_cin_q;
        pipe_v_d    = {pipe_v_q[LAT-1:0], accept};
        pipe_tag_d  = {pipe_tag_q[LAT-1:0], in_tag};
        fifo_push   = pipe_v_q[LAT];
        fifo_in     = '{s: add_s, cout: add_cout, tag: pipe_tag_q[LAT]};
        last_cout_d = fifo_push ? add_cout : last_cout_q;
    end

    // State update; reset clears the pipe valids so stale adder outputs are never captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            pipe_v_q    <= '0;
            pipe_tag_q  <= '0;
            last_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            pipe_v_q    <= pipe_v_d;
            pipe_tag_q  <= pipe_tag_d;
            last_cout_q <= last_cout_d;
        end
    end

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .pop      (out_valid && out_ready),
        .data_in  (fifo_in),
        .data_out (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_valid = !fifo_empty;
    assign out_s     = fifo_out.s;
    assign out_cout  = fifo_out.cout;
    assign out_tag   = fifo_out.tag;

endmodule
